// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU function codes and flag bit positions for the MIPS pipeline
package mips_pkg;

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;
  localparam logic [4:0] FS_SLL = 5'h0C;
  localparam logic [4:0] FS_SRL = 5'h0D;
  localparam logic [4:0] FS_SRA = 5'h0E;

  // Bit positions inside the packed {C,V,N,Z} flag vector
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  function automatic logic is_hilo_op(input logic [4:0] fs);
    return (fs == FS_MUL) || (fs == FS_DIV);
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// rtl/hilo_regfile.sv - architectural HI/LO register pair written by mul/div results
module hilo_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] wr_hi,
  input  logic [DATA_W-1:0] wr_lo,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we) begin
      hi_d = wr_hi;
      lo_d = wr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/ex_mem_hilo_stage.sv
// rtl/ex_mem_hilo_stage.sv - EX/MEM pipeline register with HI/LO ownership and overflow squash
module ex_mem_hilo_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [4:0]        ex_fs,
  input  logic [DATA_W-1:0] ex_y_hi,
  input  logic [DATA_W-1:0] ex_y_lo,
  input  logic              ex_c,
  input  logic              ex_v,
  input  logic              ex_n,
  input  logic              ex_z,
  input  logic              ex_ov_trap,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_we,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mfhi,
  input  logic              ex_mflo,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [3:0]        mem_flags,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_rf_we,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              ov_exc,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] alu_out_d, alu_out_q;
  logic [3:0]        flags_d, flags_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic              rf_we_d, rf_we_q;
  logic              mem_rd_d, mem_rd_q;
  logic              mem_wr_d, mem_wr_q;
  logic [DATA_W-1:0] st_data_d, st_data_q;
  logic              ov_exc_d, ov_exc_q;

  logic              load;
  logic              hilo_op;
  logic              trap;
  logic              hilo_we;
  logic [DATA_W-1:0] result;

  assign load    = ex_valid && !stall && !flush;
  assign hilo_op = is_hilo_op(ex_fs);
  assign trap    = ex_ov_trap && ex_v;
  // HI/LO commit only on the load edge, so a mul/div held by stall writes exactly once
  assign hilo_we = load && hilo_op;

  always_comb begin
    result = ex_y_lo;
    if (ex_mfhi)      result = hi_q;
    else if (ex_mflo) result = lo_q;
  end

  always_comb begin
    valid_d   = valid_q;
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    rd_d      = rd_q;
    rf_we_d   = rf_we_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    st_data_d = st_data_q;
    ov_exc_d  = 1'b0;
    if (flush || (!stall && !ex_valid)) begin
      valid_d  = 1'b0;
      rf_we_d  = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
    end else if (load) begin
      valid_d          = 1'b1;
      alu_out_d        = result;
      flags_d[FLAG_C]  = ex_c;
      flags_d[FLAG_V]  = ex_v;
      flags_d[FLAG_N]  = ex_n;
      flags_d[FLAG_Z]  = ex_z;
      rd_d             = ex_rd;
      st_data_d        = ex_st_data;
      // A trapped instruction stays valid so MEM/WB see the exception, but loses all side effects
      rf_we_d          = ex_rf_we && !hilo_op && !trap;
      mem_rd_d         = ex_mem_rd && !trap;
      mem_wr_d         = ex_mem_wr && !trap;
      ov_exc_d         = trap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      alu_out_q <= '0;
      flags_q   <= '0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      st_data_q <= '0;
      ov_exc_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      rd_q      <= rd_d;
      rf_we_q   <= rf_we_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      st_data_q <= st_data_d;
      ov_exc_q  <= ov_exc_d;
    end
  end

  hilo_regfile #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .reset (reset),
    .we    (hilo_we),
    .wr_hi (ex_y_hi),
    .wr_lo (ex_y_lo),
    .hi_q  (hi_q),
    .lo_q  (lo_q)
  );

  assign mem_valid   = valid_q;
  assign mem_alu_out = alu_out_q;
  assign mem_flags   = flags_q;
  assign mem_rd      = rd_q;
  assign mem_rf_we   = rf_we_q;
  assign mem_mem_rd  = mem_rd_q;
  assign mem_mem_wr  = mem_wr_q;
  assign mem_st_data = st_data_q;
  assign ov_exc      = ov_exc_q;

endmodule
